// File: rtl/mix_vga_agc_pkg.sv
// Shared types and default widths for the receive-path VGA gain controller.
// MAX_GAIN and GAIN_WIDTH are also used by the downstream thermometer stage.
package mix_vga_agc_pkg;

    localparam int GAIN_WIDTH = 3;
    localparam int MAX_GAIN   = 6;

    typedef enum logic [1:0] {
        ST_MANUAL  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DECIDE  = 2'd2,
        ST_SETTLE  = 2'd3
    } agc_state_e;

endpackage

// File: rtl/mix_vga_agc_if.sv
// Control/status bundle between the AGC sequencer and its environment.
// Signal prefixes are from the AGC's point of view (i_ into the AGC, o_ out of it).
interface mix_vga_agc_if
    import mix_vga_agc_pkg::*;
#(
    parameter int GW = GAIN_WIDTH
);
    logic          i_agc_en;
    logic [GW-1:0] i_manual_gain;
    logic          i_sample_valid;
    logic          i_sig_high;
    logic          i_sig_low;
    logic [GW-1:0] o_gain_code;
    logic          o_gain_step;
    logic          o_locked;

    modport master (
        output i_agc_en, i_manual_gain, i_sample_valid, i_sig_high, i_sig_low,
        input  o_gain_code, o_gain_step, o_locked
    );

    modport slave (
        input  i_agc_en, i_manual_gain, i_sample_valid, i_sig_high, i_sig_low,
        output o_gain_code, o_gain_step, o_locked
    );
endinterface

// File: rtl/mix_vga_agc_window.sv
// Measurement window: counts accepted samples and how many were high / low.
// o_win_done flags the sample that completes the window (combinational).
module mix_vga_agc_window
    import mix_vga_agc_pkg::*;
#(
    parameter int WIN_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_sample_valid,
    input  logic              i_sig_high,
    input  logic              i_sig_low,
    output logic [WIN_LOG2:0] o_high_cnt,
    output logic [WIN_LOG2:0] o_low_cnt,
    output logic              o_win_done
);
    localparam int CW = WIN_LOG2 + 1;
    localparam logic [CW-1:0] WIN_FULL = CW'(1 << WIN_LOG2);
    localparam logic [CW-1:0] WIN_LAST = CW'((1 << WIN_LOG2) - 1);

    logic [CW-1:0] r_sample_cnt;
    logic [CW-1:0] r_high_cnt;
    logic [CW-1:0] r_low_cnt;

    // A sample with both flags set is classified as high only.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sample_cnt <= '0;
            r_high_cnt   <= '0;
            r_low_cnt    <= '0;
        end else if (i_sample_valid && (r_sample_cnt != WIN_FULL)) begin
            r_sample_cnt <= r_sample_cnt + CW'(1);
            if (i_sig_high)
                r_high_cnt <= r_high_cnt + CW'(1);
            else if (i_sig_low)
                r_low_cnt <= r_low_cnt + CW'(1);
        end
    end

    assign o_high_cnt = r_high_cnt;
    assign o_low_cnt  = r_low_cnt;
    assign o_win_done = i_sample_valid && (r_sample_cnt == WIN_LAST);

endmodule

// File: rtl/mix_vga_agc.sv
// AGC sequencer: windowed level decisions step the VGA gain index, with a
// settling hold-off after each step; agc_en=0 forces the manual gain.
//   state   | meaning
//   MANUAL  | gain follows clamped manual_gain, counters held clear
//   MEASURE | accumulate one window of valid samples
//   DECIDE  | one cycle: step gain down/up or declare lock
//   SETTLE  | ignore samples for SETTLE_CYCLES clocks after a step
module mix_vga_agc #(
    parameter int GAIN_WIDTH    = mix_vga_agc_pkg::GAIN_WIDTH,
    parameter int MAX_GAIN      = mix_vga_agc_pkg::MAX_GAIN,
    parameter int INIT_GAIN     = 3,
    parameter int WIN_LOG2      = 4,
    parameter int HI_LIMIT      = 2,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic         clk,
    input  logic         rst,
    mix_vga_agc_if.slave bus
);
    import mix_vga_agc_pkg::*;

    localparam int CW = WIN_LOG2 + 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]         WIN_FULL = CW'(1 << WIN_LOG2);
    localparam logic [GAIN_WIDTH-1:0] GAIN_MAX = GAIN_WIDTH'(MAX_GAIN);

    agc_state_e             r_state, w_state_nxt;
    logic [GAIN_WIDTH-1:0]  r_gain, w_gain_nxt, w_manual_clamped;
    logic                   r_step, w_step_nxt;
    logic                   r_locked, w_locked_nxt;
    logic [SW-1:0]          r_settle, w_settle_nxt;
    logic [CW-1:0]          w_high_cnt, w_low_cnt;
    logic                   w_win_done, w_clear, w_count_en;

    assign w_count_en = bus.i_agc_en && (r_state == ST_MEASURE) && bus.i_sample_valid;
    assign w_clear    = !bus.i_agc_en || (r_state != ST_MEASURE);
    assign w_manual_clamped = (bus.i_manual_gain > GAIN_MAX) ? GAIN_MAX : bus.i_manual_gain;

    mix_vga_agc_window #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_window (
        .clk            (clk),
        .rst            (rst),
        .i_clear        (w_clear),
        .i_sample_valid (w_count_en),
        .i_sig_high     (bus.i_sig_high),
        .i_sig_low      (bus.i_sig_low),
        .o_high_cnt     (w_high_cnt),
        .o_low_cnt      (w_low_cnt),
        .o_win_done     (w_win_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_MEASURE;
            r_gain   <= GAIN_WIDTH'(INIT_GAIN);
            r_step   <= 1'b0;
            r_locked <= 1'b0;
            r_settle <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gain   <= w_gain_nxt;
            r_step   <= w_step_nxt;
            r_locked <= w_locked_nxt;
            r_settle <= w_settle_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gain_nxt   = r_gain;
        w_step_nxt   = 1'b0;
        w_locked_nxt = r_locked;
        w_settle_nxt = r_settle;
        // Manual override beats every state, including a pending decision.
        if (!bus.i_agc_en) begin
            w_state_nxt  = ST_MANUAL;
            w_gain_nxt   = w_manual_clamped;
            w_locked_nxt = 1'b0;
            w_settle_nxt = '0;
        end else begin
            case (r_state)
                ST_MANUAL: w_state_nxt = ST_MEASURE;
                ST_MEASURE: begin
                    if (w_win_done)
                        w_state_nxt = ST_DECIDE;
                end
                ST_DECIDE: begin
                    if ((w_high_cnt >= CW'(HI_LIMIT)) && (r_gain != '0)) begin
                        w_gain_nxt   = r_gain - GAIN_WIDTH'(1);
                        w_step_nxt   = 1'b1;
                        w_locked_nxt = 1'b0;
                        w_settle_nxt = SW'(SETTLE_CYCLES - 1);
                        w_state_nxt  = ST_SETTLE;
                    end else if ((w_low_cnt == WIN_FULL) && (r_gain < GAIN_MAX)) begin
                        w_gain_nxt   = r_gain + GAIN_WIDTH'(1);
                        w_step_nxt   = 1'b1;
                        w_locked_nxt = 1'b0;
                        w_settle_nxt = SW'(SETTLE_CYCLES - 1);
                        w_state_nxt  = ST_SETTLE;
                    end else begin
                        w_locked_nxt = 1'b1;
                        w_state_nxt  = ST_MEASURE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == '0)
                        w_state_nxt = ST_MEASURE;
                    else
                        w_settle_nxt = r_settle - SW'(1);
                end
                default: w_state_nxt = ST_MEASURE;
            endcase
        end
    end

    assign bus.o_gain_code = r_gain;
    assign bus.o_gain_step = r_step;
    assign bus.o_locked    = r_locked;

endmodule

// File: tb/tb_mix_vga_agc.sv
// Directed bench for mix_vga_agc: hand-computed gain/step/lock expectations.
module tb_mix_vga_agc;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mix_vga_agc_if bus ();

    mix_vga_agc u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic hi, input logic lo);
        bus.i_sample_valid = 1'b1;
        bus.i_sig_high     = hi;
        bus.i_sig_low      = lo;
        tick();
    endtask

    task automatic idle();
        bus.i_sample_valid = 1'b0;
        bus.i_sig_high     = 1'b0;
        bus.i_sig_low      = 1'b0;
        tick();
    endtask

    initial begin
        rst                = 1'b1;
        bus.i_agc_en       = 1'b1;
        bus.i_manual_gain  = '0;
        bus.i_sample_valid = 1'b0;
        bus.i_sig_high     = 1'b0;
        bus.i_sig_low      = 1'b0;
        tick();
        tick();
        chk("rst_gain", int'(bus.o_gain_code), 3);
        chk("rst_step", int'(bus.o_gain_step), 0);
        chk("rst_locked", int'(bus.o_locked), 0);
        rst = 1'b0;

        // Three highs in a window: decrement two edges after the 16th sample.
        for (int i = 0; i < 16; i++) sample((i == 0 || i == 5 || i == 10), 1'b0);
        chk("t1_latency", int'(bus.o_gain_code), 3);
        idle();
        chk("t1_gain", int'(bus.o_gain_code), 2);
        chk("t1_step", int'(bus.o_gain_step), 1);
        chk("t1_locked", int'(bus.o_locked), 0);
        for (int i = 0; i < 8; i++) begin
            sample(1'b1, 1'b0);
            if (i == 0) chk("t1_step_once", int'(bus.o_gain_step), 0);
        end
        for (int i = 0; i < 16; i++) sample(1'b0, 1'b0);
        idle();
        chk("t1_settle_ignored", int'(bus.o_gain_code), 2);
        chk("t1_hold_locked", int'(bus.o_locked), 1);
        chk("t1_hold_nostep", int'(bus.o_gain_step), 0);

        // All-low windows from gain 5: up to 6, then saturate as hold.
        bus.i_agc_en      = 1'b0;
        bus.i_manual_gain = 3'd5;
        tick();
        chk("t2_manual5", int'(bus.o_gain_code), 5);
        chk("t2_manual_unlock", int'(bus.o_locked), 0);
        bus.i_agc_en = 1'b1;
        tick();
        chk("t2_resume", int'(bus.o_gain_code), 5);
        for (int i = 0; i < 16; i++) sample(1'b0, 1'b1);
        idle();
        chk("t2_up_gain", int'(bus.o_gain_code), 6);
        chk("t2_up_step", int'(bus.o_gain_step), 1);
        for (int i = 0; i < 8; i++) idle();
        for (int i = 0; i < 16; i++) sample(1'b0, 1'b1);
        idle();
        chk("t2_sat_gain", int'(bus.o_gain_code), 6);
        chk("t2_sat_step", int'(bus.o_gain_step), 0);
        chk("t2_sat_locked", int'(bus.o_locked), 1);

        // Both flags set on two samples count as high: decrement.
        for (int i = 0; i < 16; i++) begin
            if (i == 3 || i == 7) sample(1'b1, 1'b1);
            else                  sample(1'b0, 1'b0);
        end
        idle();
        chk("t3_both_gain", int'(bus.o_gain_code), 5);
        chk("t3_both_step", int'(bus.o_gain_step), 1);
        for (int i = 0; i < 8; i++) idle();

        // Manual clamp and restart from an empty window.
        for (int i = 0; i < 10; i++) sample(1'b0, 1'b0);
        bus.i_agc_en      = 1'b0;
        bus.i_manual_gain = 3'd7;
        tick();
        chk("t4_clamp", int'(bus.o_gain_code), 6);
        chk("t4_manual_nostep", int'(bus.o_gain_step), 0);
        bus.i_manual_gain = 3'd2;
        tick();
        chk("t4_manual2", int'(bus.o_gain_code), 2);
        bus.i_manual_gain = 3'd7;
        tick();
        chk("t4_clamp_again", int'(bus.o_gain_code), 6);
        bus.i_agc_en = 1'b1;
        tick();
        chk("t4_resume_hold", int'(bus.o_gain_code), 6);
        for (int i = 0; i < 14; i++) sample(1'b0, 1'b0);
        sample(1'b1, 1'b0);
        sample(1'b1, 1'b0);
        chk("t4_pending", int'(bus.o_gain_code), 6);
        idle();
        chk("t4_restart_gain", int'(bus.o_gain_code), 5);
        chk("t4_restart_step", int'(bus.o_gain_step), 1);
        for (int i = 0; i < 8; i++) idle();

        // Reset mid-window clears counters; next window needs 16 samples.
        for (int i = 0; i < 10; i++) sample(1'b0, 1'b1);
        rst = 1'b1;
        tick();
        chk("t5_rst_gain", int'(bus.o_gain_code), 3);
        chk("t5_rst_step", int'(bus.o_gain_step), 0);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) sample(1'b0, 1'b1);
        idle();
        chk("t5_no_early", int'(bus.o_gain_code), 3);
        sample(1'b0, 1'b1);
        idle();
        chk("t5_full_gain", int'(bus.o_gain_code), 4);
        chk("t5_full_step", int'(bus.o_gain_step), 1);
        for (int i = 0; i < 8; i++) idle();

        // agc_en falls during DECIDE: manual wins, no step.
        for (int i = 0; i < 16; i++) sample(1'b0, 1'b1);
        bus.i_sample_valid = 1'b0;
        bus.i_agc_en       = 1'b0;
        bus.i_manual_gain  = 3'd1;
        tick();
        chk("t7_manual_wins", int'(bus.o_gain_code), 1);
        chk("t7_no_step", int'(bus.o_gain_step), 0);
        tick();
        chk("t7_no_step_late", int'(bus.o_gain_step), 0);
        bus.i_agc_en = 1'b1;
        tick();

        // Only valid cycles count toward the window.
        for (int i = 0; i < 31; i++) begin
            bus.i_sample_valid = (i % 2 == 0);
            bus.i_sig_high     = 1'b0;
            bus.i_sig_low      = 1'b1;
            tick();
            if (i == 29) chk("t6_invalid_ignored", int'(bus.o_gain_code), 1);
        end
        chk("t6_latency", int'(bus.o_gain_code), 1);
        idle();
        chk("t6_gain", int'(bus.o_gain_code), 2);
        chk("t6_step", int'(bus.o_gain_step), 1);

        // Reset during SETTLE returns to MEASURE immediately.
        for (int i = 0; i < 3; i++) idle();
        rst = 1'b1;
        tick();
        chk("t8_rst_settle_gain", int'(bus.o_gain_code), 3);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) sample(1'b0, 1'b1);
        idle();
        chk("t8_after_rst_gain", int'(bus.o_gain_code), 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
